// File: rtl/ds_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// ds_arb_pkg : arbiter state type and round-robin pick helper
// Rev 1.0
// ============================================================================
`ifndef ACX_NAP_HORIZONTAL_DATA_WIDTH
`define ACX_NAP_HORIZONTAL_DATA_WIDTH 256
`endif
`ifndef ACX_NAP_DS_ADDR_WIDTH
`define ACX_NAP_DS_ADDR_WIDTH 4
`endif

package ds_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // First set bit of valid searching upward from last+1, wrapping modulo n.
  // When nothing is valid the previous index is returned; callers gate on |valid.
  function automatic logic [MAX_IDW-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [MAX_IDW-1:0] last,
    input int                 n
  );
    logic [MAX_IDW-1:0] pick;
    logic               found;
    int                 idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if ((k <= n) && !found && valid[idx]) begin
        pick  = MAX_IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ds_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// ds_tx_arbiter_if : requester-side and NAP-side data-stream handshake bundle
// Rev 1.0
// ============================================================================
interface ds_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `ACX_NAP_HORIZONTAL_DATA_WIDTH,
  parameter int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest;
  logic [NUM_REQ-1:0]            req_eop;

  logic                          nap_valid;
  logic                          nap_ready;
  logic [DATA_WIDTH-1:0]         nap_data;
  logic [ADDR_WIDTH-1:0]         nap_addr;
  logic                          nap_sop;
  logic                          nap_eop;

  // master: the arbiter (drives the NAP and the per-requester ready)
  modport master (
    input  req_valid, req_data, req_dest, req_eop, nap_ready,
    output req_ready, nap_valid, nap_data, nap_addr, nap_sop, nap_eop
  );

  // slave: the requesters plus the NAP side, as seen from outside the arbiter
  modport slave (
    output req_valid, req_data, req_dest, req_eop, nap_ready,
    input  req_ready, nap_valid, nap_data, nap_addr, nap_sop, nap_eop
  );

endinterface

`default_nettype wire

// File: rtl/ds_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin picker over NUM_REQ valid lines
// Rev 1.0
// ============================================================================
module rr_arbiter
  import ds_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  wire  [NUM_REQ-1:0] valid,
  input  wire  [IDW-1:0]     last,
  output logic [IDW-1:0]     pick
);

  assign pick = IDW'(rr_pick(MAX_REQ'(valid), MAX_IDW'(last), NUM_REQ));

endmodule

`default_nettype wire

// File: rtl/ds_tx_arbiter.sv
`default_nettype none
// ============================================================================
// ds_tx_arbiter : packet-level round-robin share of one NAP data-stream TX port
// Rev 1.0
// ============================================================================
module ds_tx_arbiter
  import ds_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = `ACX_NAP_HORIZONTAL_DATA_WIDTH,
  parameter  int ADDR_WIDTH = `ACX_NAP_DS_ADDR_WIDTH,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  wire                   clk,
  input  wire                   resetn,
  input  wire                   arb_enable,
  ds_tx_arbiter_if.master       bus,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic [31:0]           pkt_count
);

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [IDW-1:0]          r_last_grant;
  logic [IDW-1:0]          r_grant_id;
  logic [IDW-1:0]          w_pick;
  logic [IDW-1:0]          w_acc_idx;
  logic                    r_nap_valid;
  logic                    r_nap_sop;
  logic                    r_nap_eop;
  logic [DATA_WIDTH-1:0]   r_nap_data;
  logic [ADDR_WIDTH-1:0]   r_nap_addr;
  logic [31:0]             r_pkt_count;
  logic                    w_slot_free;
  logic                    w_accept;
  logic                    w_acc_eop;
  logic [NUM_REQ-1:0]      w_req_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .valid (bus.req_valid),
    .last  (r_last_grant),
    .pick  (w_pick)
  );

  assign w_slot_free = !r_nap_valid || bus.nap_ready;
  assign w_acc_idx   = (r_state == IDLE) ? w_pick : r_grant_id;
  assign w_accept    = |(w_req_ready & bus.req_valid);
  assign w_acc_eop   = bus.req_eop[w_acc_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_acc_eop) w_next_state = LOCKED;
      LOCKED:  if (w_accept && w_acc_eop)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The lock holder keeps its ready even with req_valid low, so a stalled
  // requester never loses the NAP mid-packet.
  always_comb begin
    w_req_ready = '0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (arb_enable && w_slot_free && (|bus.req_valid)) begin
          w_req_ready[w_pick] = 1'b1;
        end
      end
      LOCKED: begin
        w_req_ready[r_grant_id] = w_slot_free;
        busy                    = 1'b1;
      end
      default: begin
        w_req_ready = '0;
      end
    endcase
    if (!resetn) begin
      w_req_ready = '0;
    end
  end

  assign bus.req_ready = w_req_ready;

  // Single output stage: a new beat replaces the current one only when the
  // slot is free, otherwise every nap_* field is held for the NAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_nap_valid <= 1'b0;
      r_nap_sop   <= 1'b0;
      r_nap_eop   <= 1'b0;
      r_nap_data  <= '0;
      r_nap_addr  <= '0;
      r_grant_id  <= '0;
    end else if (w_slot_free) begin
      r_nap_valid <= w_accept;
      if (w_accept) begin
        r_nap_data <= bus.req_data[w_acc_idx*DATA_WIDTH +: DATA_WIDTH];
        r_nap_eop  <= w_acc_eop;
        if (r_state == IDLE) begin
          r_nap_addr <= bus.req_dest[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          r_nap_sop  <= 1'b1;
          r_grant_id <= w_pick;
        end else begin
          r_nap_sop  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_pkt_count  <= '0;
    end else begin
      if (w_accept && w_acc_eop) begin
        r_last_grant <= w_acc_idx;
      end
      if (r_nap_valid && bus.nap_ready && r_nap_eop) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign bus.nap_valid = r_nap_valid;
  assign bus.nap_data  = r_nap_data;
  assign bus.nap_addr  = r_nap_addr;
  assign bus.nap_sop   = r_nap_sop;
  assign bus.nap_eop   = r_nap_eop;
  assign grant_id      = r_grant_id;
  assign pkt_count     = r_pkt_count;

  a_ready_onehot: assert property (
    @(posedge clk) disable iff (!resetn) $onehot0(w_req_ready)
  );

  a_hold_under_backpressure: assert property (
    @(posedge clk) disable iff (!resetn)
    (r_nap_valid && !bus.nap_ready) |=> (r_nap_valid && $stable(r_nap_data) && $stable(r_nap_eop))
  );

endmodule

`default_nettype wire

// File: tb/tb_ds_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ds_tx_arbiter : vector-table and scoreboard bench for ds_tx_arbiter
// Rev 1.0
// ============================================================================
module tb_ds_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 4;

  logic        clk        = 1'b0;
  logic        resetn     = 1'b0;
  logic        arb_enable = 1'b1;
  logic        busy;
  logic [1:0]  grant_id;
  logic [31:0] pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  ds_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ds_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .arb_enable (arb_enable),
    .bus        (bus),
    .busy       (busy),
    .grant_id   (grant_id),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dval(input int i, input int c);
    return 16'h00A5 + 16'(i * 256) + 16'(c);
  endfunction

  // Scoreboard: expected NAP beats built from what each requester handed over
  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t          sb[$];
  logic [NR-1:0]  first_beat;
  logic [AW-1:0]  saved_addr[NR];
  int             bcnt[NR];

  initial begin : monitor
    beat_t         e;
    logic [NR-1:0] acc;
    first_beat = '1;
    for (int i = 0; i < NR; i++) begin
      bcnt[i]       = 0;
      saved_addr[i] = '0;
      bus.req_data[i*DW +: DW] = dval(i, 0);
    end
    forever begin
      @(negedge clk);
      acc = '0;
      if (!resetn) begin
        sb.delete();
        first_beat = '1;
        for (int i = 0; i < NR; i++) begin
          bcnt[i] = 0;
          bus.req_data[i*DW +: DW] = dval(i, 0);
        end
      end else begin
        if (bus.nap_valid && bus.nap_ready) begin
          check("sb_pop_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat_data", 32'(bus.nap_data), 32'(e.data));
            check("beat_addr", 32'(bus.nap_addr), 32'(e.addr));
            check("beat_sop",  32'(bus.nap_sop),  32'(e.sop));
            check("beat_eop",  32'(bus.nap_eop),  32'(e.eop));
          end
        end
        check("req_ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        for (int i = 0; i < NR; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            if (first_beat[i]) saved_addr[i] = bus.req_dest[i*AW +: AW];
            e.data        = bus.req_data[i*DW +: DW];
            e.addr        = saved_addr[i];
            e.sop         = first_beat[i];
            e.eop         = bus.req_eop[i];
            first_beat[i] = bus.req_eop[i];
            sb.push_back(e);
            acc[i] = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          bcnt[i]++;
          bus.req_data[i*DW +: DW] = dval(i, bcnt[i]);
        end
      end
    end
  end

  // One row per clock: inputs for the cycle and the req_ready/busy/nap_valid seen before the edge
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  eop;
    logic [15:0] dest;
    logic        en;
    logic        nr;
    logic [3:0]  ready;
    logic        busy;
    logic        nv;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] valid, input logic [3:0] eop, input logic [15:0] dest,
                              input logic en, input logic nr, input logic [3:0] ready,
                              input logic bsy, input logic nv);
    vec_t v;
    v.valid = valid; v.eop = eop; v.dest = dest; v.en = en; v.nr = nr;
    v.ready = ready; v.busy = bsy; v.nv = nv;
    tbl.push_back(v);
  endfunction

  task automatic run_table(input string name);
    foreach (tbl[k]) begin
      bus.req_valid = tbl[k].valid;
      bus.req_eop   = tbl[k].eop;
      bus.req_dest  = tbl[k].dest;
      arb_enable    = tbl[k].en;
      bus.nap_ready = tbl[k].nr;
      @(negedge clk);
      check($sformatf("%s_r%0d_ready", name, k), 32'(bus.req_ready), 32'(tbl[k].ready));
      check($sformatf("%s_r%0d_busy", name, k),  32'(busy),          32'(tbl[k].busy));
      check($sformatf("%s_r%0d_nvalid", name, k), 32'(bus.nap_valid), 32'(tbl[k].nv));
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_eop   = '0;
    arb_enable    = 1'b1;
    bus.nap_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin : main
    // Reset state, with every requester asserting valid
    bus.req_valid = '1;
    bus.req_eop   = '0;
    bus.req_dest  = '0;
    bus.nap_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_nap_valid", 32'(bus.nap_valid), 32'd0);
    check("rst_nap_sop",   32'(bus.nap_sop),   32'd0);
    check("rst_nap_eop",   32'(bus.nap_eop),   32'd0);
    check("rst_nap_data",  32'(bus.nap_data),  32'd0);
    check("rst_nap_addr",  32'(bus.nap_addr),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_grant_id",  32'(grant_id),      32'd0);
    check("rst_pkt_count", pkt_count,          32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // Single-beat packet from requester 0
    do_reset();
    bus.req_dest  = 16'h0002;
    bus.req_eop   = 4'b0001;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_nap_valid", 32'(bus.nap_valid), 32'd1);
    check("t1_nap_data",  32'(bus.nap_data),  32'h00A5);
    check("t1_nap_addr",  32'(bus.nap_addr),  32'd2);
    check("t1_nap_sop",   32'(bus.nap_sop),   32'd1);
    check("t1_nap_eop",   32'(bus.nap_eop),   32'd1);
    check("t1_grant_id",  32'(grant_id),      32'd0);
    step();
    @(negedge clk);
    check("t1_pkt_count", pkt_count, 32'd1);
    check("t1_idle_valid", 32'(bus.nap_valid), 32'd0);
    step();

    // All four requesters with continuous single-beat packets: strict rotation
    do_reset();
    for (int k = 0; k < 8; k++) begin
      add(4'hF, 4'hF, 16'h4321, 1'b1, 1'b1, 4'(1 << (k % 4)), 1'b0, (k > 0));
    end
    run_table("rr");
    bus.req_valid = '0;
    step();
    @(negedge clk);
    check("rr_pkt_count", pkt_count, 32'd8);
    step();

    // 3-beat packet from requester 1 while requester 2 waits; dest changes mid-packet
    do_reset();
    add(4'b0110, 4'b0100, 16'h0970, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
    add(4'b0110, 4'b0100, 16'h09C0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1);
    add(4'b0110, 4'b0110, 16'h09C0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1);
    add(4'b0100, 4'b0100, 16'h09C0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1);
    add(4'b0000, 4'b0000, 16'h09C0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_table("lock");
    @(negedge clk);
    check("lock_pkt_count", pkt_count, 32'd2);
    check("lock_grant_id",  32'(grant_id), 32'd2);
    step();

    // nap_ready low for 5 cycles in the middle of a 4-beat packet
    do_reset();
    add(4'b0001, 4'b0000, 16'h0003, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    add(4'b0001, 4'b0000, 16'h0003, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      add(4'b0001, 4'b0000, 16'h0003, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    end
    add(4'b0001, 4'b0000, 16'h0003, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    add(4'b0001, 4'b0001, 16'h0003, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    add(4'b0000, 4'b0000, 16'h0003, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    run_table("stall");
    @(negedge clk);
    check("stall_pkt_count", pkt_count, 32'd1);
    step();

    // arb_enable drops during beat 2 of a 4-beat packet
    do_reset();
    add(4'b0001, 4'b0000, 16'h0021, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    add(4'b0001, 4'b0000, 16'h0021, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    add(4'b0001, 4'b0000, 16'h0021, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    add(4'b0001, 4'b0001, 16'h0021, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1);
    add(4'b0011, 4'b0011, 16'h0021, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    add(4'b0011, 4'b0011, 16'h0021, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_table("en");
    bus.req_valid = '0;
    arb_enable    = 1'b1;
    @(negedge clk);
    check("en_pkt_count", pkt_count, 32'd1);
    step();

    // Asynchronous reset in the middle of a packet from requester 2
    do_reset();
    bus.req_dest  = 16'h0500;
    bus.req_eop   = 4'b0000;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("ar_ready_pre", 32'(bus.req_ready), 32'b0100);
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    check("ar_nap_valid", 32'(bus.nap_valid), 32'd0);
    check("ar_nap_sop",   32'(bus.nap_sop),   32'd0);
    check("ar_nap_data",  32'(bus.nap_data),  32'd0);
    check("ar_nap_addr",  32'(bus.nap_addr),  32'd0);
    check("ar_busy",      32'(busy),          32'd0);
    check("ar_grant_id",  32'(grant_id),      32'd0);
    check("ar_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    step();
    resetn        = 1'b1;
    bus.req_eop   = 4'b0101;
    bus.req_valid = 4'b0101;
    @(negedge clk);
    check("ar_first_winner", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    repeat (3) step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ds_tx_arbiter.md
Name: ds_tx_arbiter

Overview:
- Shares one horizontal-NAP data-stream TX interface between NUM_REQ requester modules, each of which sends packets to a NoC column.
- Packet-level round-robin arbitration: once a requester wins, it keeps the NAP until its end-of-packet beat is accepted.
- A single output register stage sits between the requesters and the NAP.
- Instantiated in project_top between sender-style modules and nap_horizontal_wrapper.if_ds_tx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, `ACX_NAP_HORIZONTAL_DATA_WIDTH, data-stream payload width
ADDR_WIDTH, `ACX_NAP_DS_ADDR_WIDTH, destination address width
IDW, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports:
clk  in  1  user clock; all logic on posedge
resetn  in  1  asynchronous active-low reset
arb_enable  in  1  1 = new packets may start; 0 = finish the current packet, then start nothing
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester beat accepted
req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
req_dest  in  NUM_REQ*ADDR_WIDTH  per-requester destination; sampled on the first beat only
req_eop  in  NUM_REQ  last beat of packet
nap_valid  out  1  to if_ds_tx.valid
nap_ready  in  1  from if_ds_tx.ready
nap_data  out  DATA_WIDTH  to if_ds_tx.data
nap_addr  out  ADDR_WIDTH  to if_ds_tx.addr
nap_sop  out  1  to if_ds_tx.sop
nap_eop  out  1  to if_ds_tx.eop
busy  out  1  1 while in LOCKED state
grant_id  out  IDW  current or most recent grant index
pkt_count  out  32  number of packets whose eop has been accepted by the NAP; wraps

Behaviour:
- Reset values (async, resetn low):
  - nap_valid, nap_sop, nap_eop, busy = 0
  - nap_data, nap_addr = 0
  - grant_id = 0; last_grant = NUM_REQ-1, so requester 0 has first priority
  - pkt_count = 0; state = IDLE
  - req_ready is combinational and therefore 0 during reset.
- slot_free = !nap_valid || nap_ready. The output register accepts a new beat whenever slot_free is 1.
- pick = the first i with req_valid[i] = 1, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
- IDLE state:
  - req_ready[pick] = arb_enable && slot_free && |req_valid; all other req_ready = 0.
  - On an accepted beat, load the output register:
    - nap_data from the picked requester's data
    - nap_addr from its req_dest
    - nap_sop = 1, nap_eop = req_eop[pick]
    - grant_id = pick
  - If req_eop = 1 (single-beat packet): stay in IDLE and set last_grant = pick.
  - Otherwise: go to LOCKED.
- LOCKED state:
  - Only req_ready[grant_id] = slot_free; arb_enable is ignored.
  - On an accepted beat, load nap_data and nap_eop; nap_sop = 0; nap_addr is held from the first beat.
  - When an eop beat is accepted, return to IDLE and set last_grant = grant_id.
- Output register:
  - When slot_free is 1 and no beat is accepted, nap_valid goes to 0.
  - While nap_valid && !nap_ready, all nap_* outputs are held stable.
- Latency: a beat accepted at cycle N is presented on nap_* at cycle N+1. Back-to-back beats sustain one beat per clock while nap_ready = 1.
- Priority switch: the next packet from a different requester can be accepted in the cycle immediately after an eop beat is accepted. There is no bubble.
- pkt_count increments on nap_valid && nap_ready && nap_eop.
- Boundary conditions:
  - A requester that drops req_valid mid-packet keeps the lock. The bus idles until its next beat.
  - Simultaneous valids in IDLE: rotation guarantees every requester a slot within NUM_REQ packets.
  - arb_enable falling mid-packet: the current packet completes, then the block stays in IDLE.
  - resetn asserted mid-packet: everything clears immediately. No partial-packet recovery is attempted; the NAP shares the same resetn.

Decomposition:
- Package ds_arb_pkg holds:
  - typedef enum {IDLE, LOCKED} arb_state_t
  - function rr_pick(valid, last), which returns the round-robin index
- Sub-module rr_arbiter: pure combinational round-robin picker, parameterised by NUM_REQ, with inputs valid and last and output pick. The FSM and output register remain in ds_tx_arbiter.

Test Plan:
- Reset, then requester 0 sends a single beat (data 0xA5, dest 2, eop 1) with nap_ready = 1 -> beat appears on the NAP one cycle later with sop = 1, eop = 1, addr = 2; pkt_count = 1.
- All 4 requesters hold 1-beat packets valid continuously -> grants in order 0,1,2,3,0,...; pkt_count = 8 after 8 cycles of NAP traffic.
- Requester 1 sends a 3-beat packet while requester 2 is also valid -> requester 2 gets no ready until requester 1's eop is accepted; nap_addr stays at requester 1's dest for all 3 beats; sop only on beat 1.
- nap_ready held low for 5 cycles mid-packet -> nap_data and nap_valid are stable; req_ready = 0 for those cycles; no beat is lost or duplicated.
- arb_enable drops during beat 2 of a 4-beat packet -> the packet completes, then no req_ready is asserted while arb_enable = 0; busy = 0.
- resetn pulsed low during beat 2 of a packet -> all outputs return to reset values asynchronously; after release, requester 0 wins first.
